clk_divider: RTL and testbench

// - Integer clock divider: derives a slower clock-like signal sample_clk from vga_clk.
// - Division ratio is set by CLK_COUNT; e.g. CLK_COUNT=2 turns a 50 MHz board clock into the 25 MHz VGA pixel clock.
// - Used as the timebase feeding the VGA sync generator and other sampled logic.
// - All outputs are registered and glitch-free.

---
 rtl/clk_divider.sv | 73 +++++++
 tb/tb_clk_divider.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/clk_divider.sv
// clk_divider: integer clock divider producing a registered, glitch-free
// sample_clk with period CLK_COUNT vga_clk cycles (high for CLK_COUNT/2
// cycles, low for the remainder).
//
// Optional feature macro: CLK_DIVIDER_TICK_EN
//   When defined, adds sample_tick, a one-cycle strobe registered on the
//   same edge where sample_clk rises.
//
// Parameters:
//   CLK_COUNT  division ratio N, legal range 2..2**CNT_W
//   CNT_W      internal counter width
// Ports:
//   vga_clk      in   input clock, rising edge
//   reset        in   asynchronous, active-high reset
//   en           in   count enable; low freezes the divider
//   sample_tick  out  rise strobe (only with CLK_DIVIDER_TICK_EN)
//   sample_clk   out  divided output, registered
module clk_divider #(
   parameter int unsigned CLK_COUNT = 2,
   parameter int unsigned CNT_W     = 16
) (
   input  logic vga_clk,
   input  logic reset,
   input  logic en,
`ifdef CLK_DIVIDER_TICK_EN
   output logic sample_tick,
`endif
   output logic sample_clk
);

   localparam int unsigned HIGH = CLK_COUNT / 2;
   // Counter value on which the output rises (wrap) and on which it falls.
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_COUNT - 1);
   localparam logic [CNT_W-1:0] FALL = CNT_W'(HIGH - 1);

   // Reject ratios the counter cannot represent.
   if ((CLK_COUNT < 2) || (64'(CLK_COUNT) > (64'd1 << CNT_W))) begin : g_bad_cfg
      $error("clk_divider: CLK_COUNT out of range for CNT_W");
   end

   logic [CNT_W-1:0] cnt;
   logic             wrap_c;

   assign wrap_c = (cnt == LAST);

   // Phase counter and divided output; both freeze while en is low.
   // LAST and FALL never coincide because HIGH-1 < N-1 for N >= 2.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         cnt        <= '0;
         sample_clk <= 1'b0;
      end else if (en) begin
         cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
         if (wrap_c) begin
            sample_clk <= 1'b1;
         end else if (cnt == FALL) begin
            sample_clk <= 1'b0;
         end
      end
   end

`ifdef CLK_DIVIDER_TICK_EN
   // Strobe on the enabled wrap edge only; cleared on any other edge.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= en & wrap_c;
      end
   end
`endif

endmodule

// File: tb/tb_clk_divider.sv
// Testbench for clk_divider: four instances (N = 2, 3, 4, 7, with the
// counter width at its minimum for N = 2, 4, 7) driven by shared clock,
// reset and randomized enable, checked against an edge-count model.
module tb_clk_divider;

   localparam int NUM = 4;
   localparam int NS [NUM] = '{2, 3, 4, 7};

   logic       vga_clk = 1'b0;
   logic       reset;
   logic       en;
   logic [3:0] sc;
`ifdef CLK_DIVIDER_TICK_EN
   logic [3:0] st;
`endif

   always #5 vga_clk = ~vga_clk;

   clk_divider #(.CLK_COUNT(2), .CNT_W(1)) u_n2 (
      .vga_clk(vga_clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .sample_tick(st[0]),
`endif
      .sample_clk(sc[0]));

   clk_divider #(.CLK_COUNT(3), .CNT_W(16)) u_n3 (
      .vga_clk(vga_clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .sample_tick(st[1]),
`endif
      .sample_clk(sc[1]));

   clk_divider #(.CLK_COUNT(4), .CNT_W(2)) u_n4 (
      .vga_clk(vga_clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .sample_tick(st[2]),
`endif
      .sample_clk(sc[2]));

   clk_divider #(.CLK_COUNT(7), .CNT_W(3)) u_n7 (
      .vga_clk(vga_clk), .reset(reset), .en(en),
`ifdef CLK_DIVIDER_TICK_EN
      .sample_tick(st[3]),
`endif
      .sample_clk(sc[3]));

   int     checks = 0;
   int     errors = 0;
   longint k [NUM];      // enabled edges since last reset, per instance
   logic   prev4 = 1'b0;
   logic   rose4 = 1'b0;
   int     ticks4 = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // After kk enabled edges: high once the first wrap has happened and the
   // phase within the period is in the first floor(N/2) positions.
   function automatic logic exp_clk(input int n, input longint kk);
      return (kk >= longint'(n)) && ((kk % longint'(n)) < longint'(n / 2));
   endfunction

   function automatic logic exp_tick(input int n, input longint kk, input logic en_edge);
      return en_edge && (kk >= longint'(n)) && ((kk % longint'(n)) == 0);
   endfunction

   // One clock edge: update the model from the inputs seen at the edge,
   // then compare every instance 1 ns later.
   task automatic step();
      logic en_at;
      logic rst_at;
      @(posedge vga_clk);
      en_at  = en;
      rst_at = reset;
      #1;
      for (int i = 0; i < NUM; i++) begin
         if (rst_at) k[i] = 0;
         else if (en_at) k[i] = k[i] + 1;
         check($sformatf("clk_n%0d", NS[i]), 32'(sc[i]), 32'(exp_clk(NS[i], k[i])));
`ifdef CLK_DIVIDER_TICK_EN
         check($sformatf("tick_n%0d", NS[i]), 32'(st[i]),
               32'(exp_tick(NS[i], k[i], en_at && !rst_at)));
`endif
      end
      rose4 = sc[2] && !prev4;
      prev4 = sc[2];
`ifdef CLK_DIVIDER_TICK_EN
      if (st[2]) ticks4++;
`endif
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   initial begin
      logic [5:0] seq2;
      int         rises;
      int         waited;

      for (int i = 0; i < NUM; i++) k[i] = 0;
      reset = 1'b1;
      en    = 1'b0;

      // Reset state.
      step();
      step();
      check("reset_clk4", 32'(sc[2]), 32'd0);

      // N=2 directed sequence after release: edges 1..6 give 0,1,0,1,0,1.
      reset = 1'b0;
      en    = 1'b1;
      seq2  = 6'b101010;
      for (int e = 0; e < 6; e++) begin
         step();
         check("n2_seq", 32'(sc[0]), 32'(seq2[e]));
      end

      // N=4: 400 enabled edges after reset give exactly 100 rises.
      reset_pulse();
      rises  = 0;
      ticks4 = 0;
      for (int e = 0; e < 400; e++) begin
         step();
         if (rose4) rises++;
      end
      check("n4_rises_400", 32'(rises), 32'd100);
`ifdef CLK_DIVIDER_TICK_EN
      check("n4_ticks_400", 32'(ticks4), 32'd100);
`endif

      // N=4: freeze 5 cycles with cnt=1; the next rise is 3 enabled edges away.
      reset_pulse();
      for (int e = 0; e < 5; e++) step();
      en = 1'b0;
      for (int e = 0; e < 5; e++) step();
      check("n4_frozen_high", 32'(sc[2]), 32'd1);
      en     = 1'b1;
      waited = 0;
      do begin
         step();
         waited++;
      end while (!rose4 && waited < 20);
      check("n4_rise_after_hold", 32'(waited), 32'd3);

      // N=4: async reset in the high phase drops the output with no edge.
      waited = 0;
      do begin
         step();
         waited++;
      end while (!rose4 && waited < 20);
      check("n4_reached_high", 32'(sc[2]), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("async_rst_clk4", 32'(sc[2]), 32'd0);
      check("async_rst_clk3", 32'(sc[1]), 32'd0);
      for (int i = 0; i < NUM; i++) k[i] = 0;
      prev4 = 1'b0;
      step();
      step();
      reset  = 1'b0;
      waited = 0;
      do begin
         step();
         waited++;
      end while (!rose4 && waited < 20);
      check("n4_first_rise_after_rst", 32'(waited), 32'd4);

      // Randomized enable with occasional reset pulses.
      for (int c = 0; c < 3000; c++) begin
         step();
         en    = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 199) == 0);
      end
      reset = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
